// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//
// ID/EX pipeline register for the 5-stage RV32 core, with load-use hazard
// detection folded in. Each rising edge captures the decoded controls,
// operands, immediate and register indices of the instruction in ID. If a
// load in EX writes a register the ID instruction reads, or EX signals a
// taken branch, a bubble is loaded instead.
//
// Ports
//   clk, rst_n             core clock, asynchronous active-low reset
//   id_instruc             instruction word in ID (register indices,
//                          funct3 and funct7[5] are taken from it)
//   id_ALUOp .. id_mem_to_reg
//                          decoder control bits
//   id_pc, id_rs1_data, id_rs2_data, id_imm
//                          PC, register file reads, sign-extended immediate
//   ex_flush               branch taken in EX; squash the ID instruction
//   ex_*                   registered copies presented to the EX stage
//   ex_valid               1 = real instruction in EX, 0 = bubble
//   pc_write, if_id_write  combinational front-end enables (0 = hold)
//   stall_cnt, flush_cnt   saturating counts of stall and flush bubbles

module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [31:0]      id_instruc,
    input  logic [1:0]       id_ALUOp,
    input  logic             id_ALUSrc,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             ex_flush,

    output logic [1:0]       ex_ALUOp,
    output logic             ex_ALUSrc,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_valid,

    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic [2:0] id_funct3;
    logic       id_funct7b5;

    assign id_opcode   = id_instruc[6:0];
    assign id_rd       = id_instruc[11:7];
    assign id_funct3   = id_instruc[14:12];
    assign id_rs1      = id_instruc[19:15];
    assign id_rs2      = id_instruc[24:20];
    assign id_funct7b5 = id_instruc[30];

    // The remaining funct7 bits are decoded upstream and never needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instruc[31], id_instruc[29:25]};

    // Which source fields really are register reads for this opcode. For
    // I-type, LUI, JAL etc. the rs2 (or rs1) field is immediate bits, so a
    // match there must not cause a stall.
    logic uses_rs1;
    logic uses_rs2;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_REG, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD, OP_IMM: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    logic stall;
    logic load_bubble;

    assign stall = ex_valid & ex_mem_read & (ex_rd != 5'd0)
                 & (((ex_rd == id_rs1) & uses_rs1) | ((ex_rd == id_rs2) & uses_rs2));

    assign load_bubble = ex_flush | stall;

    // A taken branch must redirect fetch even if the squashed ID instruction
    // would otherwise have stalled, so flush overrides the hold.
    assign pc_write    = ex_flush | ~stall;
    assign if_id_write = ex_flush | ~stall;

    // Control half of the register. A bubble zeroes every control bit so
    // the slot cannot write memory, the register file, or redirect fetch.
    // mem_to_reg is a don't-care from the decoder whenever reg_write is 0
    // (stores, branches); gating it keeps the EX copy a clean 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_ALUOp      <= 2'b00;
            ex_ALUSrc     <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (load_bubble) begin
            ex_valid      <= 1'b0;
            ex_ALUOp      <= 2'b00;
            ex_ALUSrc     <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_ALUOp      <= id_ALUOp;
            ex_ALUSrc     <= id_ALUSrc;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg & id_reg_write;
        end
    end

    // Data half of the register. During a bubble nothing downstream looks
    // at these, so they simply hold rather than toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7b5 <= 1'b0;
        end else if (!load_bubble) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
        end
    end

    // Bubble statistics. A flush that coincides with a stall is counted only
    // as a flush, since the flush is the reason the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ex_flush) begin
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end else if (stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe
//
// Self-checking bench for id_ex_pipe (built with CNT_W = 4 so counter
// saturation is reachable). Each scenario task drives the ID inputs, pushes
// the EX-stage state it expects onto a scoreboard queue, and after the next
// clock edge pops that entry and compares it with the DUT outputs.

module tb_id_ex_pipe;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    // Control packing: {ALUOp[1:0], ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg}
    localparam logic [7:0] C_REG   = 8'b10_0_0_0_0_1_0;
    localparam logic [7:0] C_IMM   = 8'b10_1_0_0_0_1_0;
    localparam logic [7:0] C_LOAD  = 8'b00_1_0_1_0_1_1;
    localparam logic [7:0] C_STORE = 8'b00_1_0_0_1_0_1;

    localparam logic [31:0] ADDI_X1_X0_5  = 32'h00500093;
    localparam logic [31:0] LW_X5_0_X2    = 32'h00012283;
    localparam logic [31:0] ADD_X6_X5_X7  = 32'h00728333;
    localparam logic [31:0] ADDI_X6_X0_1  = 32'h00100313;
    localparam logic [31:0] LW_X0_0_X2    = 32'h00012003;
    localparam logic [31:0] ADD_X1_X0_X0  = 32'h000000B3;
    localparam logic [31:0] ADDI_X6_X7_5F = 32'h00538313;
    localparam logic [31:0] SW_X5_0_X2    = 32'h00512023;

    logic             clk;
    logic             rst_n;
    logic [31:0]      id_instruc;
    logic [1:0]       id_ALUOp;
    logic             id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic             ex_flush;
    logic [1:0]       ex_ALUOp;
    logic             ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5, ex_valid;
    logic             pc_write, if_id_write;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_instruc(id_instruc), .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc),
        .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .ex_flush(ex_flush),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_valid(ex_valid),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic        alusrc, branch, mem_read, mem_write, reg_write, mem_to_reg;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] pc, rs1_data, rs2_data, imm;
    } ex_t;

    ex_t sb[$];
    ex_t exp_e, obs_e, msk;
    int  passed = 0;
    int  total  = 0;
    int  exp_stall = 0;
    int  exp_flush = 0;

    function automatic ex_t sample();
        ex_t s;
        s = '{valid: ex_valid, aluop: ex_ALUOp, alusrc: ex_ALUSrc, branch: ex_branch,
              mem_read: ex_mem_read, mem_write: ex_mem_write, reg_write: ex_reg_write,
              mem_to_reg: ex_mem_to_reg, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
              funct3: ex_funct3, funct7b5: ex_funct7b5, pc: ex_pc,
              rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm};
        return s;
    endfunction

    // Expected EX state when the instruction currently in ID issues.
    function automatic ex_t issue_exp();
        ex_t e;
        e = '{valid: 1'b1, aluop: id_ALUOp, alusrc: id_ALUSrc, branch: id_branch,
              mem_read: id_mem_read, mem_write: id_mem_write, reg_write: id_reg_write,
              mem_to_reg: id_mem_to_reg, rs1: id_instruc[19:15], rs2: id_instruc[24:20],
              rd: id_instruc[11:7], funct3: id_instruc[14:12], funct7b5: id_instruc[30],
              pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm};
        return e;
    endfunction

    // Only valid + controls matter for a bubble; everything matters otherwise.
    function automatic ex_t care_mask(input ex_t e);
        ex_t m;
        m = '0;
        if (e.valid) begin
            m = '1;
        end else begin
            m.valid = 1'b1; m.aluop = 2'b11; m.alusrc = 1'b1; m.branch = 1'b1;
            m.mem_read = 1'b1; m.mem_write = 1'b1; m.reg_write = 1'b1; m.mem_to_reg = 1'b1;
        end
        return m;
    endfunction

    task automatic set_id(input logic [31:0] instr, input logic [7:0] ctrl, input logic [31:0] imm);
        id_instruc = instr;
        {id_ALUOp, id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg} = ctrl;
        id_pc       = id_pc + 32'd4;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = imm;
    endtask

    task automatic push_bubble();
        ex_t b;
        b = '0;
        sb.push_back(b);
    endtask

    // Clock the pipe once and pop the entry that edge should have produced.
    task automatic advance();
        @(posedge clk);
        #1;
        exp_e = sb.pop_front();
        obs_e = sample();
        msk   = care_mask(exp_e);
    endtask

    task automatic test_reset();
        ex_flush = 1'b0;
        id_pc    = 32'h0000_0FFC;
        set_id(ADDI_X1_X0_5, C_IMM, 32'd5);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        obs_e = sample();
        total++;
        if (obs_e !== '0) $display("[TB] FAIL reset_outputs: got %h want 0", obs_e);
        else passed++;
        total++;
        if ({pc_write, if_id_write} !== 2'b11)
            $display("[TB] FAIL reset_enables: got %b want 11", {pc_write, if_id_write});
        else passed++;
        total++;
        if ({stall_cnt, flush_cnt} !== '0)
            $display("[TB] FAIL reset_counters: got %h/%h want 0/0", stall_cnt, flush_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(issue_exp());
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL reset_addi_issue: got %h want %h", obs_e, exp_e);
        else passed++;
        total++;
        if ({ex_rd, ex_reg_write, ex_ALUSrc, ex_imm} !== {5'd1, 1'b1, 1'b1, 32'd5})
            $display("[TB] FAIL reset_addi_fields: got rd=%0d rw=%b src=%b imm=%h want rd=1 rw=1 src=1 imm=5",
                     ex_rd, ex_reg_write, ex_ALUSrc, ex_imm);
        else passed++;
    endtask

    task automatic test_load_use();
        set_id(LW_X5_0_X2, C_LOAD, 32'd0);
        sb.push_back(issue_exp());
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL load_use_lw: got %h want %h", obs_e, exp_e);
        else passed++;
        set_id(ADD_X6_X5_X7, C_REG, 32'd0);
        #1;
        total++;
        if ({pc_write, if_id_write} !== 2'b00)
            $display("[TB] FAIL load_use_hold: got %b want 00", {pc_write, if_id_write});
        else passed++;
        push_bubble();
        exp_stall++;
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL load_use_bubble: got %h want %h", obs_e, exp_e);
        else passed++;
        total++;
        if (stall_cnt !== CNT_W'(exp_stall)) $display("[TB] FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        else passed++;
        total++;
        if (pc_write !== 1'b1) $display("[TB] FAIL load_use_release: got %b want 1", pc_write);
        else passed++;
        sb.push_back(issue_exp());
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0 || ex_rs1 !== 5'd5)
            $display("[TB] FAIL load_use_add_issue: got %h want %h", obs_e, exp_e);
        else passed++;
    endtask

    task automatic test_no_false_stall();
        logic [31:0] seconds [3];
        logic [31:0] loads   [3];
        seconds = '{ADDI_X6_X0_1, ADD_X1_X0_X0, ADDI_X6_X7_5F};
        loads   = '{LW_X5_0_X2, LW_X0_0_X2, LW_X5_0_X2};
        for (int i = 0; i < 3; i++) begin
            set_id(loads[i], C_LOAD, 32'd0);
            sb.push_back(issue_exp());
            advance();
            set_id(seconds[i], (seconds[i][6:0] == 7'b0110011) ? C_REG : C_IMM, 32'(seconds[i][31:20]));
            #1;
            total++;
            if (pc_write !== 1'b1) $display("[TB] FAIL no_false_stall_%0d: got pc_write %b want 1", i, pc_write);
            else passed++;
            sb.push_back(issue_exp());
            advance();
            total++;
            if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL no_false_issue_%0d: got %h want %h", i, obs_e, exp_e);
            else passed++;
        end
    endtask

    task automatic test_flush();
        set_id(ADD_X1_X0_X0, C_REG, 32'd0);
        ex_flush = 1'b1;
        push_bubble();
        exp_flush++;
        advance();
        ex_flush = 1'b0;
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL flush_bubble: got %h want %h", obs_e, exp_e);
        else passed++;
        total++;
        if (flush_cnt !== CNT_W'(exp_flush)) $display("[TB] FAIL flush_cnt: got %0d want %0d", flush_cnt, exp_flush);
        else passed++;
    endtask

    task automatic test_flush_with_stall();
        set_id(LW_X5_0_X2, C_LOAD, 32'd0);
        sb.push_back(issue_exp());
        advance();
        set_id(ADD_X6_X5_X7, C_REG, 32'd0);
        ex_flush = 1'b1;
        #1;
        total++;
        if ({pc_write, if_id_write} !== 2'b11)
            $display("[TB] FAIL flush_stall_enables: got %b want 11", {pc_write, if_id_write});
        else passed++;
        push_bubble();
        exp_flush++;
        advance();
        ex_flush = 1'b0;
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL flush_stall_bubble: got %h want %h", obs_e, exp_e);
        else passed++;
        total++;
        if ({stall_cnt, flush_cnt} !== {CNT_W'(exp_stall), CNT_W'(exp_flush)})
            $display("[TB] FAIL flush_stall_counts: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        else passed++;
        sb.push_back(issue_exp());
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL flush_stall_after: got %h want %h", obs_e, exp_e);
        else passed++;
    endtask

    task automatic test_store_mem_to_reg();
        ex_t e;
        set_id(SW_X5_0_X2, C_STORE, 32'd0);
        e = issue_exp();
        e.mem_to_reg = 1'b0;
        sb.push_back(e);
        advance();
        total++;
        if (((obs_e ^ exp_e) & msk) !== '0) $display("[TB] FAIL store_issue: got %h want %h", obs_e, exp_e);
        else passed++;
    endtask

    task automatic test_back_to_back_saturation();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            set_id(LW_X5_0_X2, C_LOAD, 32'd0);
            sb.push_back(issue_exp());
            advance();
            if (((obs_e ^ exp_e) & msk) !== '0) bad++;
            set_id(ADD_X6_X5_X7, C_REG, 32'd0);
            push_bubble();
            if (exp_stall < CNT_SAT) exp_stall++;
            advance();
            if (((obs_e ^ exp_e) & msk) !== '0) bad++;
            sb.push_back(issue_exp());
            advance();
            if (((obs_e ^ exp_e) & msk) !== '0) bad++;
        end
        total++;
        if (bad != 0) $display("[TB] FAIL b2b_stream: got %0d bad slots want 0", bad);
        else passed++;
        total++;
        if (stall_cnt !== CNT_W'(CNT_SAT)) $display("[TB] FAIL stall_saturation: got %0d want %0d", stall_cnt, CNT_SAT);
        else passed++;
        total++;
        if (flush_cnt !== CNT_W'(exp_flush)) $display("[TB] FAIL sat_flush_cnt: got %0d want %0d", flush_cnt, exp_flush);
        else passed++;
    endtask

    task automatic test_async_reset();
        set_id(LW_X5_0_X2, C_LOAD, 32'd0);
        sb.push_back(issue_exp());
        advance();
        set_id(ADD_X6_X5_X7, C_REG, 32'd0);
        #1;
        total++;
        if (pc_write !== 1'b0) $display("[TB] FAIL async_pre_stall: got pc_write %b want 0", pc_write);
        else passed++;
        rst_n = 1'b0;
        #1;
        obs_e = sample();
        total++;
        if (obs_e !== '0) $display("[TB] FAIL async_reset_outputs: got %h want 0", obs_e);
        else passed++;
        total++;
        if ({pc_write, if_id_write, stall_cnt, flush_cnt} !== {2'b11, {(2*CNT_W){1'b0}}})
            $display("[TB] FAIL async_reset_misc: got en=%b cnt=%0d/%0d want en=11 cnt=0/0",
                     {pc_write, if_id_write}, stall_cnt, flush_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_flush_with_stall();
        test_store_mem_to_reg();
        test_back_to_back_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
